// File: rtl/apb4_cmd_master_pkg.sv
// apb4_cmd_master_pkg: shared types and constants for the APB4 command requester.
// Contents:
//   PROT_WIDTH - width of the APB4 PPROT attribute
//   state_e    - requester FSM states (IDLE, SETUP, ACCESS, RESP)
package apb4_cmd_master_pkg;

    localparam int PROT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

endpackage

// File: rtl/apb4_cmd_master_if.sv
// apb4_cmd_master_if: APB4 bus bundle between a requester and a completer.
// Signals:
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb - driven by the requester
//   pready, prdata, pslverr                             - driven by the completer
// Modports: master (requester side), slave (completer side).
interface apb4_cmd_master_if
    import apb4_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [PROT_WIDTH-1:0]   pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_cmd_master_tmo.sv
// apb4_cmd_master_tmo: saturating wait-state counter flagging a hung APB transfer.
// Ports:
//   clk_i, rst_n_i - clock, asynchronous active-low reset
//   clr_i          - clear the counter (has priority over en_i)
//   en_i           - count one wait state
//   expired_o      - counter has reached TIMEOUT_CYCLES-1; constant 0 when TIMEOUT_CYCLES = 0
module apb4_cmd_master_tmo #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i && cnt_q != '1)
            cnt_q <= cnt_q + CW'(1);
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            assign expired_o = cnt_q == CW'(TIMEOUT_CYCLES - 1);
        end
    endgenerate
endmodule

// File: rtl/apb4_cmd_master.sv
// apb4_cmd_master: turns a valid/ready command stream into single APB4 transfers.
// Ports:
//   clk_i, rst_n_i        - clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   - command handshake; ready only while idle
//   cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i - command fields
//   rsp_valid_o/ready_i   - response handshake
//   rsp_rdata_o, rsp_err_o, rsp_timeout_o - response fields (held until consumed)
//   apb                   - APB4 requester bus (master modport)
module apb4_cmd_master
    import apb4_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic [PROT_WIDTH-1:0]   cmd_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    apb4_cmd_master_if.master       apb
);
    typedef struct packed {
        logic                    write;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] strb;
        logic [PROT_WIDTH-1:0]   prot;
    } cmd_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    state_e state_q, state_d;
    cmd_t   cmd_q;
    rsp_t   rsp_q;
    logic   expired, done, abort;

    assign done  = state_q == ACCESS && apb.pready;
    assign abort = state_q == ACCESS && !apb.pready && expired;

    // Counter only runs during ACCESS, so it is zero whenever a transfer starts.
    apb4_cmd_master_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (state_q != ACCESS),
        .en_i      (state_q == ACCESS && !apb.pready),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid_i ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = done || abort ? RESP : ACCESS;
            RESP:    state_d = rsp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = state_q == IDLE;
        rsp_valid_o = state_q == RESP;
        apb.psel    = state_q == SETUP || state_q == ACCESS;
        apb.penable = state_q == ACCESS;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q <= '0;
            rsp_q <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid_i)
                cmd_q <= '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i,
                           strb: cmd_write_i ? cmd_strb_i : '0, prot: cmd_prot_i};
            if (done)
                rsp_q <= '{rdata: cmd_q.write ? '0 : apb.prdata, err: apb.pslverr, timeout: 1'b0};
            else if (abort)
                rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
        end
    end

    assign apb.paddr   = cmd_q.addr;
    assign apb.pwrite  = cmd_q.write;
    assign apb.pwdata  = cmd_q.wdata;
    assign apb.pstrb   = cmd_q.strb;
    assign apb.pprot   = cmd_q.prot;
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;
endmodule

// File: tb/tb_apb4_cmd_master.sv
// tb_apb4_cmd_master: self-checking bench for apb4_cmd_master with an APB completer model.
module tb_apb4_cmd_master;
    import apb4_cmd_master_pkg::*;

    localparam int AW = 32, DW = 32, SW = DW / 8, TMO = 8, NDIR = 7, NRND = 24;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            waits;
        logic          slverr;
        logic [DW-1:0] rdata;
        int            bp;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_tmo;
        int            exp_lat;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic [SW-1:0] cmd_strb_i = '0;
    logic [2:0]    cmd_prot_i = '0;
    logic          rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, rsp_timeout_o;
    logic [DW-1:0] rsp_rdata_o;

    int passed = 0, total = 0;
    vec_t vecs[NDIR + NRND];

    always #5 clk_i = ~clk_i;

    apb4_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb4_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_strb_i    (cmd_strb_i),
        .cmd_prot_i    (cmd_prot_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .apb           (apb)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: a transfer completes on the first ACCESS cycle with PREADY high,
    // unless PREADY stayed low for TMO ACCESS cycles, in which case it is aborted.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_tmo   = TMO != 0 && v.waits >= TMO;
        r.exp_err   = r.exp_tmo || v.slverr;
        r.exp_rdata = (r.exp_tmo || v.write) ? '0 : v.rdata;
        r.exp_lat   = 3 + (r.exp_tmo ? TMO - 1 : v.waits);
        return r;
    endfunction

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                                input logic se, input logic [DW-1:0] rd, input int bp,
                                input logic [DW-1:0] er, input logic ee, input logic et, input int el);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p; v.waits = waits;
        v.slverr = se; v.rdata = rd; v.bp = bp;
        v.exp_rdata = er; v.exp_err = ee; v.exp_tmo = et; v.exp_lat = el;
        return v;
    endfunction

    task automatic run(input vec_t v, input int idx);
        int lat, k = 0;
        logic [SW-1:0] exp_strb = v.write ? v.strb : '0;
        logic [71:0] exp_bus = {v.addr, v.write, exp_strb, v.prot, v.wdata};
        chk($sformatf("v%0d idle_ready", idx), {cmd_ready_o, rsp_valid_o, apb.psel}, 3'b100);
        cmd_valid_i = 1'b1; cmd_write_i = v.write; cmd_addr_i = v.addr;
        cmd_wdata_i = v.wdata; cmd_strb_i = v.strb; cmd_prot_i = v.prot;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0; cmd_addr_i = $urandom(); cmd_wdata_i = $urandom(); cmd_write_i = ~v.write;
        chk($sformatf("v%0d setup_ctl", idx), {apb.psel, apb.penable, cmd_ready_o}, 3'b100);
        chk($sformatf("v%0d setup_bus", idx),
            {apb.paddr, apb.pwrite, apb.pstrb, apb.pprot, apb.pwdata}, exp_bus);
        for (lat = 2; lat <= 40; lat++) begin
            @(negedge clk_i);
            if (rsp_valid_o) break;
            chk($sformatf("v%0d access%0d", idx, k),
                {apb.psel, apb.penable, apb.paddr, apb.pwrite, apb.pstrb, apb.pprot, apb.pwdata},
                {2'b11, exp_bus});
            apb.pready  = k == v.waits;
            apb.prdata  = k == v.waits ? v.rdata : $urandom();
            apb.pslverr = k == v.waits ? v.slverr : 1'($urandom_range(0, 1));
            k++;
        end
        apb.pready = 1'b0; apb.pslverr = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d rsp", idx), {rsp_rdata_o, rsp_err_o, rsp_timeout_o},
            {v.exp_rdata, v.exp_err, v.exp_tmo});
        chk($sformatf("v%0d resp_ctl", idx), {apb.psel, apb.penable, cmd_ready_o}, 3'b000);
        cmd_valid_i = v.bp > 0;
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk_i);
            chk($sformatf("v%0d backpressure%0d", idx, i),
                {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, apb.psel, cmd_ready_o},
                {1'b1, v.exp_rdata, v.exp_err, v.exp_tmo, 2'b00});
        end
        cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk($sformatf("v%0d after_hs", idx), {rsp_valid_o, cmd_ready_o, apb.psel}, 3'b010);
    endtask

    initial begin
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        vecs[0] = mk(1, 'h10, 'hDEADBEEF, 'hF, 3'd0, 0, 0, 'h0,        0, 'h0,        0, 0, 3);
        vecs[1] = mk(0, 'h20, 'hCAFEF00D, 'hF, 3'd2, 3, 0, 'h12345678, 0, 'h12345678, 0, 0, 6);
        vecs[2] = mk(1, 'h30, 'h0BADC0DE, 'h3, 3'd1, 1, 1, 'h55555555, 0, 'h0,        1, 0, 4);
        vecs[3] = mk(0, 'h40, 'h0,        'hF, 3'd0, 8, 0, 'hA5A5A5A5, 0, 'h0,        1, 1, 10);
        vecs[4] = mk(0, 'h44, 'h0,        'hF, 3'd4, 7, 0, 'h5A5A5A5A, 0, 'h5A5A5A5A, 0, 0, 10);
        vecs[5] = mk(0, 'h48, 'h0,        'h1, 3'd7, 2, 1, 'hFEEDFACE, 0, 'hFEEDFACE, 1, 0, 5);
        vecs[6] = mk(1, 'h50, 'h13579BDF, 'hC, 3'd5, 0, 0, 'h0,        5, 'h0,        0, 0, 3);
        for (int i = NDIR; i < NDIR + NRND; i++) begin
            vec_t v;
            v.write = 1'($urandom_range(0, 1)); v.addr = $urandom(); v.wdata = $urandom();
            v.strb = 4'($urandom()); v.prot = 3'($urandom()); v.waits = $urandom_range(0, 10);
            v.slverr = $urandom_range(0, 3) == 0; v.rdata = $urandom(); v.bp = $urandom_range(0, 3);
            vecs[i] = model(v);
        end

        #1;
        chk("reset_ctl", {cmd_ready_o, apb.psel, apb.penable, rsp_valid_o}, 4'b1000);
        chk("reset_rsp", {rsp_rdata_o, rsp_err_o, rsp_timeout_o}, '0);
        chk("reset_bus", {apb.paddr, apb.pwrite, apb.pstrb, apb.pprot, apb.pwdata}, '0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < NDIR + NRND; i++) run(vecs[i], i);

        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 'h60; cmd_strb_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_pre_access", {apb.psel, apb.penable, rsp_valid_o}, 3'b110);
        rst_n_i = 1'b0;
        #1;
        chk("rst_mid_access", {apb.psel, apb.penable, rsp_valid_o, cmd_ready_o}, 4'b0001);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("rst_released", {apb.psel, apb.penable, rsp_valid_o, cmd_ready_o}, 4'b0001);
        run(vecs[1], 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
